// File: rtl/grid_arbiter_if.sv
// Bus bundle shared by the requesters, the grid arbiter and the grid RAM.
// The arbiter uses the slave side; the requesters and RAM together form the master side.
interface grid_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*32-1:0] addr;
    logic [N_REQ*32-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [31:0]         rdata;
    logic                lock_err;
    logic                mem_read;
    logic                mem_write;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_din;
    logic [31:0]         mem_dout;

    modport slave (
        input  req, we, lock, addr, wdata, mem_dout,
        output gnt, rvalid, rdata, lock_err, mem_read, mem_write, mem_addr, mem_din
    );

    modport master (
        output req, we, lock, addr, wdata, mem_dout,
        input  gnt, rvalid, rdata, lock_err, mem_read, mem_write, mem_addr, mem_din
    );
endinterface

// File: rtl/grid_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to a shared grid RAM,
// with single-cycle writes, two-cycle reads and bounded lock tenures for read-modify-write.
module grid_arbiter #(
    parameter int                 N_REQ      = 4,
    parameter int                 DEPTH_LOG2 = 4,
    parameter int                 LOCK_MAX   = 64,
    parameter logic signed [31:0] OOB_VALUE  = -32'sd2
) (
    input  logic          clk,
    input  logic          reset,
    grid_arbiter_if.slave bus
);
    localparam int          PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          TW    = $clog2(LOCK_MAX + 1);
    localparam logic [32:0] DEPTH = 33'd1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, LOCKED} state_t;

    state_t           state_q, state_n;
    logic [PW-1:0]    ptr_q, ptr_n;
    logic [PW-1:0]    owner_q, owner_n;
    logic             hold_q, hold_n;
    logic             tenure_on_q, tenure_on_n;
    logic [TW-1:0]    tenure_q, tenure_n;
    logic             rd_oob_q, rd_oob_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [N_REQ-1:0] rvalid_q, rvalid_n;
    logic             mem_read_q, mem_read_n;
    logic             mem_write_q, mem_write_n;
    logic [31:0]      mem_addr_q, mem_addr_n;
    logic [31:0]      mem_din_q, mem_din_n;
    logic             lock_err_q, lock_err_n;

    logic [N_REQ-1:0] cand;
    logic [PW-1:0]    win;
    logic             found;
    logic             do_grant;
    logic             timeout;
    logic [31:0]      w_addr;
    logic [31:0]      w_data;
    logic             w_we;
    logic             w_lock;
    logic             w_oob;

    // While locked only the owner may compete; during a read wait nobody may.
    always_comb begin
        cand = '0;
        if (state_q == IDLE) begin
            cand = bus.req;
        end else if (state_q == LOCKED) begin
            cand[owner_q] = bus.req[owner_q];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && cand[PW'((int'(ptr_q) + i) % N_REQ)]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    assign w_addr  = bus.addr[32*int'(win) +: 32];
    assign w_data  = bus.wdata[32*int'(win) +: 32];
    assign w_we    = bus.we[win];
    assign w_lock  = bus.lock[win];
    assign w_oob   = ({1'b0, w_addr} >= DEPTH);
    assign timeout = tenure_on_q && (state_q != IDLE) && (tenure_q == TW'(LOCK_MAX - 1));

    always_comb begin
        state_n     = state_q;
        ptr_n       = ptr_q;
        owner_n     = owner_q;
        hold_n      = hold_q;
        tenure_on_n = tenure_on_q;
        tenure_n    = tenure_q;
        rd_oob_n    = rd_oob_q;
        gnt_n       = '0;
        rvalid_n    = '0;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_din_n   = mem_din_q;
        lock_err_n  = lock_err_q;
        do_grant    = 1'b0;

        if (tenure_on_q && (state_q != IDLE)) begin
            tenure_n = tenure_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                do_grant = found;
            end
            RD_WAIT: begin
                rvalid_n[owner_q] = 1'b1;
                state_n = hold_q ? LOCKED : IDLE;
            end
            LOCKED: begin
                if (!timeout) begin
                    if (!bus.req[owner_q] && !bus.lock[owner_q]) begin
                        state_n = IDLE;
                    end else begin
                        do_grant = found;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Out-of-range accesses are still granted but never strobe the RAM.
        if (do_grant) begin
            gnt_n[win]  = 1'b1;
            ptr_n       = win;
            owner_n     = win;
            hold_n      = w_lock;
            rd_oob_n    = w_oob;
            mem_addr_n  = w_addr;
            mem_din_n   = w_data;
            mem_read_n  = !w_we && !w_oob;
            mem_write_n = w_we && !w_oob;
            if (w_we) begin
                state_n = w_lock ? LOCKED : IDLE;
            end else begin
                state_n = RD_WAIT;
            end
            if (state_q == IDLE) begin
                tenure_on_n = w_lock;
                tenure_n    = '0;
            end
        end

        if (timeout) begin
            state_n    = IDLE;
            lock_err_n = 1'b1;
            ptr_n      = owner_q;
        end

        if (state_n == IDLE) begin
            tenure_on_n = 1'b0;
            tenure_n    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(N_REQ - 1);
            owner_q     <= '0;
            hold_q      <= 1'b0;
            tenure_on_q <= 1'b0;
            tenure_q    <= '0;
            rd_oob_q    <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            ptr_q       <= ptr_n;
            owner_q     <= owner_n;
            hold_q      <= hold_n;
            tenure_on_q <= tenure_on_n;
            tenure_q    <= tenure_n;
            rd_oob_q    <= rd_oob_n;
            gnt_q       <= gnt_n;
            rvalid_q    <= rvalid_n;
            mem_read_q  <= mem_read_n;
            mem_write_q <= mem_write_n;
            mem_addr_q  <= mem_addr_n;
            mem_din_q   <= mem_din_n;
            lock_err_q  <= lock_err_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = (|rvalid_q) ? (rd_oob_q ? OOB_VALUE : bus.mem_dout) : '0;
    assign bus.lock_err  = lock_err_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
endmodule

// File: doc/grid_arbiter.md
GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the grid RAM.
REQ-002 Parameter DEPTH_LOG2, default 4: the grid RAM holds 2^DEPTH_LOG2 words, giving legal addresses 0..2^DEPTH_LOG2-1.
REQ-003 Parameter LOCK_MAX, default 64: maximum number of cycles a single lock tenure may last.
REQ-004 Parameter OOB_VALUE, default -2 (32-bit signed): read data returned for an out-of-range read.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 req  in  N_REQ  per-requester access request, held until granted.
REQ-008 we  in  N_REQ  per-requester access type: 1 = write, 0 = read.
REQ-009 lock  in  N_REQ  per-requester request to keep ownership after the grant, for read-check-then-write.
REQ-010 addr  in  N_REQ*32  packed signed addresses; requester k occupies bits [32k+31:32k].
REQ-011 wdata  in  N_REQ*32  packed write data, same packing as addr.
REQ-012 gnt  out  N_REQ  one-hot grant pulse, or all zero.
REQ-013 rvalid  out  N_REQ  one-hot read-data-valid pulse.
REQ-014 rdata  out  32  read data shared by all requesters; meaningful only while rvalid is nonzero.
REQ-015 lock_err  out  1  sticky flag: a lock was forcibly released.
REQ-016 mem_read, mem_write  out  1 each  strobes to the grid RAM.
REQ-017 mem_addr, mem_din  out  32 each  address and write data to the grid RAM.
REQ-018 mem_dout  in  32  grid RAM read data, valid the cycle after mem_read is high.

Function
REQ-019 States: IDLE, RD_WAIT, LOCKED; all outputs are registered except rdata.
REQ-020 IDLE with any req bit set: choose a winner by round-robin, searching from (last winner + 1) mod N_REQ; at the next edge assert gnt[w] for exactly one cycle.
REQ-021 That same edge also drives mem_addr = addr[w], and drives mem_read = !we[w] or mem_write = we[w] (with mem_din = wdata[w]) for exactly one cycle.
REQ-022 The winner deasserts or changes req only after seeing gnt; the arbiter samples addr, wdata, we and lock only at the grant edge.
REQ-023 Read grant: state moves to RD_WAIT; in the following cycle rvalid[w] = 1 and rdata = mem_dout; no grant is issued during RD_WAIT.
REQ-024 Write grant: no wait state; a new grant may be issued on the very next cycle.
REQ-025 Read-to-rvalid latency is 1 cycle after gnt; maximum throughput is one write per cycle or one read per 2 cycles.
REQ-026 Out of range (addr < 0 or addr >= 2^DEPTH_LOG2): gnt is still asserted but no memory strobe is issued.
REQ-027 An out-of-range read still passes through RD_WAIT, with rvalid[w] = 1 and rdata = OOB_VALUE.
REQ-028 If lock[w] = 1 at grant, then after the access completes the state is LOCKED with owner w; only owner requests are granted, and other req bits wait.
REQ-029 LOCKED exits to IDLE on the first cycle the owner has req = 0 and lock = 0.
REQ-030 A lock-tenure counter starts at the grant edge and increments every cycle while the state is LOCKED or RD_WAIT with owner w.
REQ-031 When the lock-tenure counter reaches LOCK_MAX: force IDLE, set lock_err, and make the owner lowest priority.
REQ-032 An owner access granted while LOCKED whose lock input is 0 releases the lock after that access completes.
REQ-033 The round-robin pointer is updated on every grant, including grants made while LOCKED.
REQ-034 Simultaneous request with the winner's rvalid cycle: the rvalid cycle completes first; arbitration resumes the cycle after.
REQ-035 gnt, rvalid, mem_read and mem_write are never asserted for more than one requester or access per cycle, and mem_read and mem_write are never high together.

Reset
REQ-036 While reset is high: gnt = 0, rvalid = 0, mem_read = mem_write = 0, mem_addr = mem_din = 0, lock_err = 0, state = IDLE, pointer set so requester 0 has highest priority, lock-tenure counter = 0.
REQ-037 Reset asserted mid-transaction (RD_WAIT or LOCKED) aborts it immediately; no rvalid is produced afterwards for the aborted read.

Verification
REQ-038 After reset, req = 4'b1111, all we = 0, addr = 3,5,7,9 -> gnt order 0,1,2,3; mem_addr 3,5,7,9; each rvalid one cycle after its gnt; one grant per 2 cycles.
REQ-039 Requester 2 writes addr 6 data 2, then requester 1 reads addr 6 -> rvalid[1] = 1 and rdata = 2.
REQ-040 Requester 0 reads addr 16, then addr -1 -> no mem_read; rvalid[0] with rdata = -2 both times.
REQ-041 Requester 3 sends lock = 1 with a read of addr 4, then a write of addr 4 data 3 with lock = 0, while requesters 0 and 1 request throughout -> 0 and 1 are not granted until after the write; lock_err stays 0.
REQ-042 Requester 1 holds lock = 1 and req = 0 for 70 cycles with another requester pending -> forced release at 64 cycles, lock_err = 1, the pending requester is granted next.
REQ-043 Reset asserted during RD_WAIT -> all outputs zero immediately; no rvalid after reset is released.
